// File: rtl/scu_control_unit_pkg.sv
// rtl/scu_control_unit_pkg.sv - opcode, ALU, PC-source encodings, FSM states and decode helpers for the SCU control unit
package scu_control_unit_pkg;

    // Instruction opcodes, field [31:28]
    localparam logic [3:0] OP_NOP  = 4'b0000;
    localparam logic [3:0] OP_ST   = 4'b0011;
    localparam logic [3:0] OP_ADD  = 4'b0100;
    localparam logic [3:0] OP_INC  = 4'b0101;
    localparam logic [3:0] OP_NEG  = 4'b0110;
    localparam logic [3:0] OP_SUB  = 4'b0111;
    localparam logic [3:0] OP_J    = 4'b1000;
    localparam logic [3:0] OP_BRZ  = 4'b1001;
    localparam logic [3:0] OP_JM   = 4'b1010;
    localparam logic [3:0] OP_BRN  = 4'b1011;
    localparam logic [3:0] OP_LD   = 4'b1110;
    localparam logic [3:0] OP_SVPC = 4'b1111;

    // ALU operation select
    localparam logic [2:0] ALU_ADD  = 3'b100;
    localparam logic [2:0] ALU_INC  = 3'b010;
    localparam logic [2:0] ALU_NEG  = 3'b001;
    localparam logic [2:0] ALU_SUB  = 3'b000;
    localparam logic [2:0] ALU_PASS = 3'b111;

    // PC source select
    localparam logic [1:0] PC_SEQ = 2'b00;
    localparam logic [1:0] PC_RS  = 2'b01;
    localparam logic [1:0] PC_MEM = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_WB     = 3'd3,
        ST_MEM    = 3'd4,
        ST_BR     = 3'd5
    } state_e;

    // Opcodes 0001, 0010, 1100 and 1101 are unassigned
    function automatic logic op_is_legal(input logic [3:0] op);
        case (op)
            OP_NOP, OP_ST, OP_ADD, OP_INC, OP_NEG, OP_SUB,
            OP_J, OP_BRZ, OP_JM, OP_BRN, OP_LD, OP_SVPC: return 1'b1;
            default:                                    return 1'b0;
        endcase
    endfunction

    function automatic logic op_is_branch(input logic [3:0] op);
        return (op == OP_J) || (op == OP_BRZ) || (op == OP_BRN);
    endfunction

    function automatic logic op_is_mem(input logic [3:0] op);
        return (op == OP_LD) || (op == OP_ST) || (op == OP_JM);
    endfunction

    // Only these four instructions update the Z/N flags at write-back
    function automatic logic op_is_arith(input logic [3:0] op);
        return (op == OP_ADD) || (op == OP_INC) || (op == OP_NEG) || (op == OP_SUB);
    endfunction

    // SVPC uses the adder on the PC/imm operand; memory ops pass the address through
    function automatic logic [2:0] alu_code(input logic [3:0] op);
        case (op)
            OP_ADD, OP_SVPC: return ALU_ADD;
            OP_INC:          return ALU_INC;
            OP_NEG:          return ALU_NEG;
            OP_SUB:          return ALU_SUB;
            default:         return ALU_PASS;
        endcase
    endfunction

    function automatic logic branch_taken(input logic [3:0] op, input logic z, input logic n);
        return (op == OP_J) || ((op == OP_BRZ) && z) || ((op == OP_BRN) && n);
    endfunction

endpackage

// File: rtl/scu_wait_timer.sv
// rtl/scu_wait_timer.sv - 8-bit wait counter that flags expiry on its TIMEOUT-1 count
module scu_wait_timer #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst_n_i,
    input  logic clr_i,
    input  logic en_i,
    output logic expire_o
);

    localparam logic [7:0] LAST = 8'(TIMEOUT - 1);

    logic [7:0] cnt_q;

    // Count enabled cycles from zero, holding at the last value until cleared
    always_ff @(posedge clk) begin
        if (!rst_n_i || clr_i) begin
            cnt_q <= 8'd0;
        end else if (en_i && (cnt_q != LAST)) begin
            cnt_q <= cnt_q + 8'd1;
        end
    end

    assign expire_o = en_i && (cnt_q == LAST);

endmodule

// File: rtl/scu_control_unit.sv
// rtl/scu_control_unit.sv - multi-cycle SCU decode/sequence FSM driving ALU, register file, memory and PC mux
module scu_control_unit #(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        in_rst_n,
    input  logic [31:0] in_instr,
    input  logic        in_instr_valid,
    output logic        out_instr_ready,
    input  logic        in_alu_zero,
    input  logic        in_alu_neg,
    output logic [2:0]  out_ctrl_aluop,
    output logic [5:0]  out_rd,
    output logic [5:0]  out_rs,
    output logic [5:0]  out_rt,
    output logic        out_ctrl_regwrite,
    output logic        out_ctrl_memtoreg,
    output logic        out_ctrl_svpc,
    output logic        out_mem_req,
    output logic        out_mem_we,
    input  logic        in_mem_ack,
    output logic [1:0]  out_ctrl_pcsrc,
    output logic        out_err
);

    import scu_control_unit_pkg::*;

    state_e      state_q, state_d;
    logic [3:0]  op_q, op_d;
    logic [5:0]  rd_q, rd_d;
    logic [5:0]  rs_q, rs_d;
    logic [5:0]  rt_q, rt_d;
    logic        flag_z_q, flag_z_d;
    logic        flag_n_q, flag_n_d;

    logic        ready_q, ready_d;
    logic [2:0]  aluop_q, aluop_d;
    logic        svpc_q, svpc_d;
    logic        wb_write_q, wb_write_d;
    logic        mem_req_q, mem_req_d;
    logic        mem_we_q, mem_we_d;
    logic [1:0]  pcsrc_q, pcsrc_d;
    logic        dec_err_q, dec_err_d;

    logic        timer_expire;
    logic        mem_done;
    logic        mem_timeout;
    logic        unused_instr_bits;

    // The immediate/low field is not needed by the control path
    assign unused_instr_bits = ^in_instr[9:0];

    scu_wait_timer #(
        .TIMEOUT (MEM_TIMEOUT)
    ) u_mem_timer (
        .clk      (clk),
        .rst_n_i  (in_rst_n),
        .clr_i    (state_q != ST_MEM),
        .en_i     (state_q == ST_MEM),
        .expire_o (timer_expire)
    );

    // Memory completion and timeout are seen in the same cycle as the ack/expiry;
    // a reset in that cycle suppresses them so no write or jump escapes
    assign mem_done    = in_rst_n && (state_q == ST_MEM) && in_mem_ack;
    assign mem_timeout = in_rst_n && (state_q == ST_MEM) && !in_mem_ack && timer_expire;

    // Next state, instruction latch and flag update
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        rd_d     = rd_q;
        rs_d     = rs_q;
        rt_d     = rt_q;
        flag_z_d = flag_z_q;
        flag_n_d = flag_n_q;
        case (state_q)
            ST_IDLE: begin
                if (in_instr_valid) begin
                    op_d    = in_instr[31:28];
                    rd_d    = in_instr[27:22];
                    rs_d    = in_instr[21:16];
                    rt_d    = in_instr[15:10];
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
                if ((op_q == OP_NOP) || !op_is_legal(op_q)) begin
                    state_d = ST_IDLE;
                end else if (op_is_branch(op_q)) begin
                    state_d = ST_BR;
                end else begin
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                state_d = op_is_mem(op_q) ? ST_MEM : ST_WB;
            end
            ST_WB: begin
                state_d = ST_IDLE;
                if (op_is_arith(op_q)) begin
                    flag_z_d = in_alu_zero;
                    flag_n_d = in_alu_neg;
                end
            end
            ST_MEM: begin
                if (in_mem_ack || timer_expire) begin
                    state_d = ST_IDLE;
                end
            end
            ST_BR: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Moore outputs for the state being entered, registered alongside it
    always_comb begin
        ready_d    = (state_d == ST_IDLE);
        dec_err_d  = (state_d == ST_DECODE) && !op_is_legal(op_d);
        aluop_d    = (state_d == ST_EXEC) ? alu_code(op_d) : ALU_PASS;
        svpc_d     = (state_d == ST_EXEC) && (op_d == OP_SVPC);
        wb_write_d = (state_d == ST_WB);
        mem_req_d  = (state_d == ST_MEM);
        mem_we_d   = (state_d == ST_MEM) && (op_d == OP_ST);
        pcsrc_d    = ((state_d == ST_BR) && branch_taken(op_d, flag_z_d, flag_n_d)) ? PC_RS : PC_SEQ;
    end

    // State, latched instruction, flags and registered outputs
    always_ff @(posedge clk) begin
        if (!in_rst_n) begin
            state_q    <= ST_IDLE;
            op_q       <= OP_NOP;
            rd_q       <= 6'd0;
            rs_q       <= 6'd0;
            rt_q       <= 6'd0;
            flag_z_q   <= 1'b0;
            flag_n_q   <= 1'b0;
            ready_q    <= 1'b1;
            dec_err_q  <= 1'b0;
            aluop_q    <= ALU_PASS;
            svpc_q     <= 1'b0;
            wb_write_q <= 1'b0;
            mem_req_q  <= 1'b0;
            mem_we_q   <= 1'b0;
            pcsrc_q    <= PC_SEQ;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            rd_q       <= rd_d;
            rs_q       <= rs_d;
            rt_q       <= rt_d;
            flag_z_q   <= flag_z_d;
            flag_n_q   <= flag_n_d;
            ready_q    <= ready_d;
            dec_err_q  <= dec_err_d;
            aluop_q    <= aluop_d;
            svpc_q     <= svpc_d;
            wb_write_q <= wb_write_d;
            mem_req_q  <= mem_req_d;
            mem_we_q   <= mem_we_d;
            pcsrc_q    <= pcsrc_d;
        end
    end

    assign out_instr_ready   = ready_q;
    assign out_ctrl_aluop    = aluop_q;
    assign out_ctrl_svpc     = svpc_q;
    assign out_rd            = rd_q;
    assign out_rs            = rs_q;
    assign out_rt            = rt_q;
    assign out_mem_req       = mem_req_q;
    assign out_mem_we        = mem_we_q;
    assign out_ctrl_regwrite = in_rst_n && (wb_write_q || (mem_done && (op_q == OP_LD)));
    assign out_ctrl_memtoreg = mem_done && (op_q == OP_LD);
    assign out_ctrl_pcsrc    = !in_rst_n ? PC_SEQ :
                               (mem_done && (op_q == OP_JM)) ? PC_MEM : pcsrc_q;
    assign out_err           = (in_rst_n && dec_err_q) || mem_timeout;

endmodule
